multu_divu_hilo: RTL and testbench
==================================

Name: multu_divu_hilo

Overview:
Multi-cycle unsigned multiply/divide unit that owns the HI/LO register pair. It sits beside the combinational ALU in the execute stage. It accepts MULTU and DIVU by funct code, iterates for 32 cycles, and commits results to HI/LO. It serves MFHI and MFLO reads back to the ALU result mux, and stalls the pipeline while an operation is in flight.

Parameters:
WIDTH, 32, operand width and HI/LO register width.
CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
valid  input  1  the funct, dataA and dataB inputs carry a live instruction this cycle.
funct  input  6  R-type funct field.
dataA  input  WIDTH  rs operand: multiplicand or dividend.
dataB  input  WIDTH  rt operand: multiplier or divisor.
dataOut  output  WIDTH  HI when funct is MFHI, LO when funct is MFLO, otherwise 0; combinational.
busy  output  1  an operation is in progress.
stall  output  1  combinational; equals valid AND busy AND funct in {MULTU, DIVU, MFHI, MFLO}.
done  output  1  one-cycle pulse in the cycle after HI/LO commit.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE; HI=0, LO=0; counter and working registers are cleared; busy=0, done=0. Any operation in flight is abandoned and produces no commit and no done pulse.
- Funct codes: MULTU=6'b011001, DIVU=6'b011011, MFHI=6'b010000, MFLO=6'b010010. All other codes are ignored.
- States:
  - IDLE: busy=0.
  - MUL and DIV: busy=1.
- Start condition: in IDLE, with valid=1 and funct equal to MULTU or DIVU, the operands are latched at edge k. State moves to MUL or DIV and the counter is loaded with WIDTH.
- Iteration: one step per edge at k+1 through k+32. The counter decrements each step. On the edge where the counter reaches 0:
  - HI and LO are written;
  - state returns to IDLE;
  - done is registered high for exactly one cycle.
- Latency: busy is high for exactly 32 cycles. MFHI/MFLO issued in the cycle after the commit edge (the done cycle) reads the new values.
- MULTU algorithm: shift-add. The product register P is 2*WIDTH bits, initialised to {0, dataB}. Each step:
  - if P[0]=1, P[upper] = P[upper] + A, computed at WIDTH+1 bits to keep the carry;
  - then {carry, P} is shifted right by 1.
  - At commit: HI = P[2W-1:W], LO = P[W-1:0].
- DIVU algorithm: restoring division. The remainder R is WIDTH+1 bits, initialised to 0; the quotient register Q is initialised to dataA. Each step:
  - {R, Q} is shifted left by 1;
  - if R >= B, R = R - B and Q[0] = 1.
  - At commit: LO = Q (quotient), HI = R[W-1:0] (remainder).
- Divide by zero: no special path. The algorithm naturally yields LO=all-ones and HI=dividend. Timing is identical to normal division (32 cycles).
- Start while busy: MULTU or DIVU issued while busy=1 is not accepted. The stall output is asserted, and the instruction must be held by the pipeline and re-presented.
- MFHI/MFLO while busy: stall=1. dataOut shows the old HI/LO value, and the consumer discards it.
- HI/LO stability: HI and LO change only on the commit edge or on reset. Partial results are never visible on dataOut.
- valid=0: no state change is started, and stall=0.

Decomposition:
- Shared package holds:
  - funct constants: MULTU, DIVU, MFHI, MFLO, plus the existing AND, OR, ADD, SUB, SLT and SLL;
  - the state encoding: IDLE=2'd0, MUL=2'd1, DIV=2'd2.
- One sub-module is natural: muldiv_step, a combinational single-iteration datapath. Its inputs are mode, the working registers and the operands; its outputs are the next working registers. The top level keeps the FSM, the counter, HI/LO and the read mux.

Test Plan:
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF -> busy high for 32 cycles; done pulses once; HI=0xFFFFFFFE, LO=0x00000001; MFHI then returns 0xFFFFFFFE.
- DIVU with A=100, B=7 -> after 32 cycles LO=14 and HI=2; MFLO returns 14; MFHI returns 2.
- DIVU with A=0x00001234, B=0 -> after 32 cycles LO=0xFFFFFFFF and HI=0x00001234; busy lasts exactly 32 cycles.
- MULTU (3×5) started, then MFLO issued at cycle 10 -> stall=1 and HI/LO unchanged until commit. A second MULTU issued while busy -> not accepted. After done, MFLO returns 15.
- reset pulled low at cycle 15 of MULTU 0x10000×0x10000 -> immediately HI=0, LO=0, busy=0; no done pulse. A DIVU 9/3 issued after release gives LO=3, HI=0.
- Back-to-back: MULTU 6×7 issued on the done cycle -> accepted; the previous result is already readable via MFLO=42 before the new commit.

Source files
------------

// File: rtl/multu_divu_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: R-type funct codes
// and the sequencer state encoding.
package multu_divu_hilo_pkg;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] AND   = 6'b100100;
  localparam logic [5:0] OR    = 6'b100101;
  localparam logic [5:0] ADD   = 6'b100000;
  localparam logic [5:0] SUB   = 6'b100010;
  localparam logic [5:0] SLT   = 6'b101010;
  localparam logic [5:0] SLL   = 6'b000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide; purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH:0]     r,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p_nxt,
  output logic [WIDTH:0]     r_nxt,
  output logic [WIDTH-1:0]   q_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] q_sh;

  always_comb begin
    sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : '0);
    // two guard bits so the top bit of diff is a clean borrow (R < B)
    r_sh  = {r, q[WIDTH-1]};
    diff  = r_sh - {2'b00, b};
    q_sh  = {q[WIDTH-2:0], 1'b0};
    p_nxt = p;
    r_nxt = r;
    q_nxt = q;
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        r_nxt = diff[WIDTH:0];
        q_nxt = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_nxt = r_sh[WIDTH:0];
        q_nxt = q_sh;
      end
    end else begin
      p_nxt = {sum, p[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multu_divu_hilo.sv
// Multi-cycle MULTU/DIVU sequencer owning HI/LO; serves MFHI/MFLO and stalls
// the pipeline while an operation is in flight.
module multu_divu_hilo
  import multu_divu_hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a, b, q, hi, lo;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH:0]     r;
  logic [2*WIDTH-1:0] p_nxt;
  logic [WIDTH:0]     r_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic               start;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (state == DIV),
    .p      (p),
    .r      (r),
    .q      (q),
    .a      (a),
    .b      (b),
    .p_nxt  (p_nxt),
    .r_nxt  (r_nxt),
    .q_nxt  (q_nxt)
  );

  assign start   = valid && (funct == MULTU || funct == DIVU);
  assign busy    = (state != IDLE);
  assign stall   = valid && busy &&
                   (funct == MULTU || funct == DIVU || funct == MFHI || funct == MFLO);
  assign dataOut = (funct == MFHI) ? hi : (funct == MFLO) ? lo : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      a     <= '0;
      b     <= '0;
      p     <= '0;
      r     <= '0;
      q     <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a     <= dataA;
          b     <= dataB;
          p     <= {{WIDTH{1'b0}}, dataB};
          r     <= '0;
          q     <= dataA;
          cnt   <= CNT_W'(WIDTH);
          state <= (funct == DIVU) ? DIV : MUL;
        end
        default: begin
          p   <= p_nxt;
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt - CNT_W'(1);
          // last step: HI/LO take the final working values directly
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
            if (state == DIV) begin
              hi <= r_nxt[WIDTH-1:0];
              lo <= q_nxt;
            end else begin
              hi <= p_nxt[2*WIDTH-1:WIDTH];
              lo <= p_nxt[WIDTH-1:0];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multu_divu_hilo.sv
// Randomized + directed bench for multu_divu_hilo against a latency/arithmetic model.
module tb_multu_divu_hilo;
  import multu_divu_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [5:0]  funct = ADD;
  logic [31:0] dataA = '0, dataB = '0;
  logic [31:0] dataOut;
  logic        busy, stall, done;

  multu_divu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .valid(valid), .funct(funct),
    .dataA(dataA), .dataB(dataB), .dataOut(dataOut),
    .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  // model: remaining busy cycles, pending result, architectural HI/LO
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_rem = 0;
  logic        m_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_clear();
    m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    logic [63:0] prod;
    if (!reset) begin
      model_clear();
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = m_phi; m_lo = m_plo; m_done = 1'b1;
        end
      end else if (valid && (funct == MULTU || funct == DIVU)) begin
        if (funct == MULTU) begin
          prod  = {32'd0, dataA} * {32'd0, dataB};
          m_phi = prod[63:32];
          m_plo = prod[31:0];
        end else if (dataB == 0) begin
          m_phi = dataA;
          m_plo = 32'hFFFF_FFFF;
        end else begin
          m_phi = dataA % dataB;
          m_plo = dataA / dataB;
        end
        m_rem = 32;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] exp_out();
    return (funct == MFHI) ? m_hi : (funct == MFLO) ? m_lo : 32'd0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_rem > 0);
      chk("done", done, m_done);
      chk("stall", stall, valid && (m_rem > 0) &&
          (funct == MULTU || funct == DIVU || funct == MFHI || funct == MFLO));
      chk("dataOut", dataOut, exp_out());
    end
  end

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    valid = 1'b1; funct = f; dataA = a; dataB = b;
    step();
    valid = 1'b0; funct = ADD;
    n = 0;
    while (busy === 1'b1 && n < 100) begin step(); n++; end
    chk("busy_len", n, 32);
    chk("done_pulse", done, 1'b1);
  endtask

  task automatic rd(input logic [5:0] f, input logic [31:0] exp, input string name);
    valid = 1'b1; funct = f;
    #1 chk(name, dataOut, exp);
    step();
    valid = 1'b0; funct = ADD;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ndone, n;
    step(); step();
    chk_en = 1'b1;
    // reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    funct = MFHI; #1 chk("rst_hi", dataOut, 32'd0);
    funct = MFLO; #1 chk("rst_lo", dataOut, 32'd0);
    funct = ADD;
    step();
    reset = 1'b1;
    step();

    // MULTU max x max
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(MFHI, 32'hFFFF_FFFE, "mul_max_hi");
    rd(MFLO, 32'h0000_0001, "mul_max_lo");

    // DIVU 100/7
    run_op(DIVU, 32'd100, 32'd7);
    rd(MFLO, 32'd14, "div_lo");
    rd(MFHI, 32'd2, "div_hi");

    // divide by zero
    run_op(DIVU, 32'h0000_1234, 32'd0);
    rd(MFLO, 32'hFFFF_FFFF, "div0_lo");
    rd(MFHI, 32'h0000_1234, "div0_hi");

    // MFLO and a second MULTU while busy
    valid = 1'b1; funct = MULTU; dataA = 3; dataB = 5;
    step();
    valid = 1'b0; funct = ADD;
    for (int i = 1; i < 10; i++) step();
    valid = 1'b1; funct = MFLO;
    #1 chk("busy_mflo_stall", stall, 1'b1);
    chk("busy_mflo_old", dataOut, 32'hFFFF_FFFF);
    step();
    funct = MULTU; dataA = 2; dataB = 2;
    #1 chk("busy_multu_stall", stall, 1'b1);
    step(); step();
    valid = 1'b0; funct = ADD;
    n = 0;
    while (busy === 1'b1 && n < 100) begin step(); n++; end
    chk("wait_3x5", n < 100, 1'b1);
    rd(MFLO, 32'd15, "mul_3x5_lo");
    rd(MFHI, 32'd0, "mul_3x5_hi");

    // async reset mid-operation
    valid = 1'b1; funct = MULTU; dataA = 32'h10000; dataB = 32'h10000;
    step();
    valid = 1'b0; funct = ADD;
    for (int i = 1; i < 15; i++) step();
    reset = 1'b0; model_clear();
    #1 chk("arst_busy", busy, 1'b0);
    funct = MFLO; #1 chk("arst_lo", dataOut, 32'd0);
    funct = MFHI; #1 chk("arst_hi", dataOut, 32'd0);
    funct = ADD;
    step(); step();
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin step(); if (done === 1'b1) ndone++; end
    chk("arst_no_done", ndone, 0);
    run_op(DIVU, 32'd9, 32'd3);
    rd(MFLO, 32'd3, "div_9_3_lo");
    rd(MFHI, 32'd0, "div_9_3_hi");

    // back-to-back: new MULTU on the done cycle
    run_op(MULTU, 32'd6, 32'd7);
    valid = 1'b1; funct = MULTU; dataA = 8; dataB = 9;
    step();
    valid = 1'b0; funct = ADD;
    chk("b2b_accept", busy, 1'b1);
    valid = 1'b1; funct = MFLO;
    #1 chk("b2b_old_lo", dataOut, 32'd42);
    step();
    valid = 1'b0; funct = ADD;
    n = 0;
    while (busy === 1'b1 && n < 100) begin step(); n++; end
    chk("wait_8x9", n < 100, 1'b1);
    rd(MFLO, 32'd72, "b2b_new_lo");

    // random traffic, with occasional reset
    for (int i = 0; i < 2000; i++) begin
      valid = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 6))
        0, 1: funct = MULTU;
        2, 3: funct = DIVU;
        4: funct = MFHI;
        5: funct = MFLO;
        default: funct = 6'($urandom_range(0, 63));
      endcase
      dataA = pick_operand();
      dataB = pick_operand();
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0; model_clear();
        step();
        reset = 1'b1;
      end
      step();
    end
    valid = 1'b0; funct = ADD;
    n = 0;
    while (busy === 1'b1 && n < 100) begin step(); n++; end
    rd(MFHI, m_hi, "final_hi");
    rd(MFLO, m_lo, "final_lo");

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
